noc_local_sink: RTL

Synthesizable ejection endpoint for one router LOCAL output port of the mesh NoC. It consumes flits through the valid/ready handshake and decodes the `{src_x, src_y, timestamp}` payload stamp written by traffic injectors. It also checks that the flit reached the correct destination, computes network latency against a local cycle counter, and keeps running statistics. One instance sits on each mesh node's `LOCAL` out-port, in both bench and FPGA bring-up builds.

---
 rtl/noc_local_sink_pkg.sv | 24 ++
 rtl/noc_lfsr16.sv | 34 +++
 rtl/noc_local_sink.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/noc_local_sink_pkg.sv
// Shared NoC definitions: payload stamp layout, mesh geometry and the LFSR step.
// Injectors and sinks both build/decode payloads through noc_stamp_t.
package noc_local_sink_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned MESH_SIDE   = 4;
    localparam int unsigned CW          = $clog2(MESH_SIDE);
    localparam int unsigned SRC_COORD_W = 4;
    localparam int unsigned TS_W        = DATA_WIDTH - 8;

    typedef struct packed {
        logic [SRC_COORD_W-1:0] src_x;
        logic [SRC_COORD_W-1:0] src_y;
        logic [TS_W-1:0]        ts;
    } noc_stamp_t;

    // Fibonacci LFSR, taps 16,14,13,11 (maximal length).
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR with a loadable nonzero seed and advance enable.
// Shared by the local sink backpressure generator and synthesizable injectors.
module noc_lfsr16
    import noc_local_sink_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = lfsr16_next(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/noc_local_sink.sv
// Ejection endpoint on a router LOCAL port: accepts flits, decodes the source stamp,
// checks the destination, measures latency and keeps saturating running statistics.
module noc_local_sink
    import noc_local_sink_pkg::*;
#(
    parameter int unsigned MY_X       = 0,
    parameter int unsigned MY_Y       = 0,
    parameter int unsigned STALL_MODE = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [CW-1:0]             in_dx,
    input  logic [CW-1:0]             in_dy,
    input  logic                      in_sdx,
    input  logic                      in_sdy,
    input  logic                      clr_stats,
    output logic                      rx_event,
    output logic [3:0]                rx_src_x,
    output logic [3:0]                rx_src_y,
    output logic [TS_W-1:0]           rx_latency,
    output logic                      rx_misroute,
    output logic [CNT_WIDTH-1:0]      pkt_cnt,
    output logic [CNT_WIDTH-1:0]      err_cnt,
    output logic [TS_W-1:0]           lat_min,
    output logic [TS_W-1:0]           lat_max,
    output logic [CNT_WIDTH+TS_W-1:0] lat_sum
);

    localparam int unsigned SUM_W  = CNT_WIDTH + TS_W;
    localparam int unsigned SUM_XW = SUM_W + 1;
    localparam logic [CW-1:0]        MY_X_C  = CW'(MY_X);
    localparam logic [CW-1:0]        MY_Y_C  = CW'(MY_Y);
    localparam logic [TS_W-1:0]      TS_ONE  = TS_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [15:0] lfsr_state;
    logic        lfsr_en;
    logic        accept;
    noc_stamp_t  in_stamp;
    logic        unused_ok;

    logic [TS_W-1:0]        now_q;
    logic                   ready_q;
    logic                   s1_v_q;
    noc_stamp_t             s1_stamp_q;
    logic [CW-1:0]          s1_dx_q;
    logic [CW-1:0]          s1_dy_q;
    logic [TS_W-1:0]        s1_now_q;
    logic                   s2_v_q;
    logic [3:0]             s2_src_x_q;
    logic [3:0]             s2_src_y_q;
    logic [TS_W-1:0]        s2_lat_q;
    logic                   s2_mis_q;
    logic                   rx_event_q;
    logic [3:0]             rx_src_x_q;
    logic [3:0]             rx_src_y_q;
    logic [TS_W-1:0]        rx_lat_q;
    logic                   rx_mis_q;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic [TS_W-1:0]        lat_min_q, lat_min_d;
    logic [TS_W-1:0]        lat_max_q, lat_max_d;
    logic [SUM_W-1:0]       lat_sum_q, lat_sum_d;
    logic [SUM_XW-1:0]      sum_ext;

    assign lfsr_en = (STALL_MODE != 0);

    noc_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (lfsr_en),
        .state(lfsr_state)
    );

    assign accept    = in_valid && ready_q;
    assign in_stamp  = noc_stamp_t'(in_data);
    assign unused_ok = ^{in_sdx, in_sdy, lfsr_state[15:2]};

    // lat_min starts at all-ones, so a plain min() also handles the first sample.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        lat_min_d = lat_min_q;
        lat_max_d = lat_max_q;
        lat_sum_d = lat_sum_q;
        sum_ext   = {1'b0, lat_sum_q} + SUM_XW'(s2_lat_q);
        if (clr_stats) begin
            pkt_cnt_d = '0;
            err_cnt_d = '0;
            lat_min_d = '1;
            lat_max_d = '0;
            lat_sum_d = '0;
        end else if (s2_v_q) begin
            pkt_cnt_d = (pkt_cnt_q == '1) ? pkt_cnt_q : pkt_cnt_q + CNT_ONE;
            if (s2_mis_q && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
            lat_sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            lat_min_d = (s2_lat_q < lat_min_q) ? s2_lat_q : lat_min_q;
            lat_max_d = (s2_lat_q > lat_max_q) ? s2_lat_q : lat_max_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            now_q      <= '0;
            ready_q    <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_stamp_q <= '0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            s1_now_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_src_x_q <= '0;
            s2_src_y_q <= '0;
            s2_lat_q   <= '0;
            s2_mis_q   <= 1'b0;
            rx_event_q <= 1'b0;
            rx_src_x_q <= '0;
            rx_src_y_q <= '0;
            rx_lat_q   <= '0;
            rx_mis_q   <= 1'b0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
            lat_min_q  <= '1;
            lat_max_q  <= '0;
            lat_sum_q  <= '0;
        end else begin
            now_q   <= now_q + TS_ONE;
            ready_q <= lfsr_en ? (lfsr_state[0] | lfsr_state[1]) : 1'b1;

            s1_v_q <= accept;
            if (accept) begin
                s1_stamp_q <= in_stamp;
                s1_dx_q    <= in_dx;
                s1_dy_q    <= in_dy;
                s1_now_q   <= now_q;
            end

            // Modular subtraction makes timestamp wrap transparent.
            s2_v_q     <= s1_v_q;
            s2_src_x_q <= s1_stamp_q.src_x;
            s2_src_y_q <= s1_stamp_q.src_y;
            s2_lat_q   <= s1_now_q - s1_stamp_q.ts;
            s2_mis_q   <= (s1_dx_q != MY_X_C) || (s1_dy_q != MY_Y_C);

            rx_event_q <= s2_v_q;
            if (s2_v_q) begin
                rx_src_x_q <= s2_src_x_q;
                rx_src_y_q <= s2_src_y_q;
                rx_lat_q   <= s2_lat_q;
                rx_mis_q   <= s2_mis_q;
            end

            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
            lat_min_q <= lat_min_d;
            lat_max_q <= lat_max_d;
            lat_sum_q <= lat_sum_d;
        end
    end

    assign in_ready    = ready_q;
    assign rx_event    = rx_event_q;
    assign rx_src_x    = rx_src_x_q;
    assign rx_src_y    = rx_src_y_q;
    assign rx_latency  = rx_lat_q;
    assign rx_misroute = rx_mis_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign lat_min     = lat_min_q;
    assign lat_max     = lat_max_q;
    assign lat_sum     = lat_sum_q;

endmodule
